// File: rtl/mult_pipe_if.sv
// Handshake bundle between the issue logic, the multiply unit and the
// completion arbiter. The unit itself connects through the slave modport.
interface mult_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
);
    // Issue side
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_func;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;

    // Completion side
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    // Issue logic / completion arbiter view
    modport master (
        output in_valid, in_func, in_rs1, in_rs2, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    // Multiply unit view
    modport slave (
        input  in_valid, in_func, in_rs1, in_rs2, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mult_pipe.sv
// Pipelined XLEN x XLEN integer multiplier for the execute stage.
// Supports the four RISC-V M-extension multiply flavours. Each of the
// STAGES register stages retires XLEN/STAGES multiplier bits (LSB first)
// into a 2*XLEN-bit running sum. A tag rides along with every operation.
// The whole pipe freezes when the result at the tail is not taken, and a
// synchronous flush invalidates everything in flight.
module mult_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 8,
    parameter int TAG_W  = 6
) (
    input logic         clock,
    input logic         reset,   // asynchronous, active low
    mult_pipe_if.slave  bus
);

    localparam int CHUNK = XLEN / STAGES;   // multiplier bits consumed per stage
    localparam int PW    = 2 * XLEN;        // full product width

    // Encodings of in_func; MULHU (2'b11) needs no special handling
    // beyond selecting the high half.
    localparam logic [1:0] FUNC_MUL    = 2'b00;
    localparam logic [1:0] FUNC_MULH   = 2'b01;
    localparam logic [1:0] FUNC_MULHSU = 2'b10;

    // ------------------------------------------------------------------
    // Stage registers (index gi = contents after stage gi)
    // ------------------------------------------------------------------
    logic             valid_q  [STAGES];
    logic [1:0]       func_q   [STAGES];
    logic [TAG_W-1:0] tag_q    [STAGES];
    logic             neg_q    [STAGES];   // MULH with negative rs2: correct at the tail
    logic [PW-1:0]    sum_q    [STAGES];
    logic [PW-1:0]    mcand_q  [STAGES];
    logic [XLEN-1:0]  mplier_q [STAGES];
    logic [XLEN-1:0]  out_result_q;

    // ------------------------------------------------------------------
    // Per-stage next-state values
    // ------------------------------------------------------------------
    logic             valid_d   [STAGES];
    logic [1:0]       func_d    [STAGES];
    logic [TAG_W-1:0] tag_d     [STAGES];
    logic             neg_d     [STAGES];
    logic [PW-1:0]    sum_in    [STAGES];  // running sum entering the stage
    logic [PW-1:0]    mcand_in  [STAGES];  // shifted multiplicand entering the stage
    logic [XLEN-1:0]  mplier_in [STAGES];  // unconsumed multiplier bits entering the stage
    logic [PW-1:0]    sum_step  [STAGES];
    logic [PW-1:0]    sum_d     [STAGES];
    logic [PW-1:0]    mcand_d   [STAGES];
    logic [XLEN-1:0]  mplier_d  [STAGES];
    logic [XLEN-1:0]  result_d;

    logic advance;     // the whole pipe moves one step this cycle
    logic accept;      // an operation enters stage 0 this cycle
    logic rs1_signed;  // rs1 is treated as a signed value

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // The pipe can only move if the tail is empty or being drained.
    assign advance  = !valid_q[STAGES-1] || bus.out_ready;

    // While reset is held the unit is empty and ready; a flush cycle
    // refuses new work so nothing slips past the kill.
    assign bus.in_ready = (reset == 1'b0) ? 1'b1 : (advance && !bus.flush);
    assign accept       = bus.in_valid && advance && !bus.flush;

    assign rs1_signed = (bus.in_func == FUNC_MULH) || (bus.in_func == FUNC_MULHSU);

    assign bus.out_valid  = valid_q[STAGES-1];
    assign bus.out_tag    = tag_q[STAGES-1];
    assign bus.out_result = out_result_q;

    // ------------------------------------------------------------------
    // Datapath, one slice per stage
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_src
                // Stage 0 starts a fresh product from the issue ports.
                assign valid_d[gi]   = accept;
                assign func_d[gi]    = bus.in_func;
                assign tag_d[gi]     = bus.in_tag;
                assign neg_d[gi]     = (bus.in_func == FUNC_MULH) && bus.in_rs2[XLEN-1];
                assign sum_in[gi]    = '0;
                assign mcand_in[gi]  = {{XLEN{rs1_signed & bus.in_rs1[XLEN-1]}}, bus.in_rs1};
                assign mplier_in[gi] = bus.in_rs2;
            end else begin : g_src
                // Later stages continue the product held by the previous stage.
                assign valid_d[gi]   = valid_q[gi-1];
                assign func_d[gi]    = func_q[gi-1];
                assign tag_d[gi]     = tag_q[gi-1];
                assign neg_d[gi]     = neg_q[gi-1];
                assign sum_in[gi]    = sum_q[gi-1];
                assign mcand_in[gi]  = mcand_q[gi-1];
                assign mplier_in[gi] = mplier_q[gi-1];
            end

            // Partial product of the shifted multiplicand with the next
            // CHUNK multiplier bits; everything wraps at 2*XLEN bits.
            assign sum_step[gi] = sum_in[gi]
                                + (mcand_in[gi] * PW'(mplier_in[gi][CHUNK-1:0]));
            assign mcand_d[gi]  = mcand_in[gi] << CHUNK;
            assign mplier_d[gi] = mplier_in[gi] >> CHUNK;

            if (gi == STAGES - 1) begin : g_tail
                // All multiplier bits were taken as unsigned. For MULH with a
                // negative rs2 the top bit really weighs -2^(XLEN-1), so remove
                // rs1 * 2^XLEN once. After the last shift mcand_d holds exactly
                // the extended rs1 shifted left by XLEN.
                assign sum_d[gi] = neg_d[gi] ? (sum_step[gi] - mcand_d[gi]) : sum_step[gi];
            end else begin : g_body
                assign sum_d[gi] = sum_step[gi];
            end
        end
    endgenerate

    // Pick the half of the finished product the operation asked for.
    always_comb begin
        result_d = sum_d[STAGES-1][XLEN-1:0];
        if (func_d[STAGES-1] != FUNC_MUL) begin
            result_d = sum_d[STAGES-1][PW-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Shift the pipe on advance; data only loads behind a valid operation so
    // bubbles keep their old (defined) contents. Flush kills every valid bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s]  <= 1'b0;
                func_q[s]   <= '0;
                tag_q[s]    <= '0;
                neg_q[s]    <= 1'b0;
                sum_q[s]    <= '0;
                mcand_q[s]  <= '0;
                mplier_q[s] <= '0;
            end
            out_result_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (bus.flush) begin
                    valid_q[s] <= 1'b0;
                end else if (advance) begin
                    valid_q[s] <= valid_d[s];
                end

                if (advance && valid_d[s]) begin
                    func_q[s]   <= func_d[s];
                    tag_q[s]    <= tag_d[s];
                    neg_q[s]    <= neg_d[s];
                    sum_q[s]    <= sum_d[s];
                    mcand_q[s]  <= mcand_d[s];
                    mplier_q[s] <= mplier_d[s];
                end
            end

            if (advance && valid_d[STAGES-1]) begin
                out_result_q <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: a 64-bit/8-stage instance for the
// directed scenarios, plus three 32-bit instances (1, 4 and 32 stages)
// fed the same random stream and checked against plain-arithmetic models.
module tb_mult_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // cycle index: number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 64-bit, 8-stage DUT ----------------
    mult_pipe_if #(.XLEN(64), .TAG_W(6)) b64 ();
    mult_pipe #(.XLEN(64), .STAGES(8), .TAG_W(6)) dut64 (
        .clock (clk), .reset (rst_n), .bus (b64.slave)
    );

    // ---------------- 32-bit sweep DUTs ----------------
    logic        sw_valid;
    logic [1:0]  sw_func;
    logic [31:0] sw_rs1, sw_rs2;
    logic [5:0]  sw_tag;
    logic        sw_ov [3];
    logic        sw_ir [3];
    logic [31:0] sw_res [3];
    logic [5:0]  sw_tg [3];
    int          sw_stages [3] = '{1, 4, 32};

    mult_pipe_if #(.XLEN(32), .TAG_W(6)) s1 ();
    mult_pipe_if #(.XLEN(32), .TAG_W(6)) s4 ();
    mult_pipe_if #(.XLEN(32), .TAG_W(6)) s32 ();

    mult_pipe #(.XLEN(32), .STAGES(1),  .TAG_W(6)) dut_s1  (.clock(clk), .reset(rst_n), .bus(s1.slave));
    mult_pipe #(.XLEN(32), .STAGES(4),  .TAG_W(6)) dut_s4  (.clock(clk), .reset(rst_n), .bus(s4.slave));
    mult_pipe #(.XLEN(32), .STAGES(32), .TAG_W(6)) dut_s32 (.clock(clk), .reset(rst_n), .bus(s32.slave));

    assign s1.in_valid = sw_valid;  assign s1.in_func = sw_func;  assign s1.in_rs1 = sw_rs1;
    assign s1.in_rs2 = sw_rs2;      assign s1.in_tag = sw_tag;    assign s1.flush = 1'b0;
    assign s1.out_ready = 1'b1;
    assign s4.in_valid = sw_valid;  assign s4.in_func = sw_func;  assign s4.in_rs1 = sw_rs1;
    assign s4.in_rs2 = sw_rs2;      assign s4.in_tag = sw_tag;    assign s4.flush = 1'b0;
    assign s4.out_ready = 1'b1;
    assign s32.in_valid = sw_valid; assign s32.in_func = sw_func; assign s32.in_rs1 = sw_rs1;
    assign s32.in_rs2 = sw_rs2;     assign s32.in_tag = sw_tag;   assign s32.flush = 1'b0;
    assign s32.out_ready = 1'b1;

    assign sw_ov[0] = s1.out_valid;   assign sw_res[0] = s1.out_result;   assign sw_tg[0] = s1.out_tag;
    assign sw_ov[1] = s4.out_valid;   assign sw_res[1] = s4.out_result;   assign sw_tg[1] = s4.out_tag;
    assign sw_ov[2] = s32.out_valid;  assign sw_res[2] = s32.out_result;  assign sw_tg[2] = s32.out_tag;
    assign sw_ir[0] = s1.in_ready;    assign sw_ir[1] = s4.in_ready;      assign sw_ir[2] = s32.in_ready;

    // ---------------- reference models ----------------
    // Exact product of the operands read as the mode says, then the half asked for.
    function automatic logic [63:0] ref64(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        ea = (f == 2'b01 || f == 2'b10) ? {{64{a[63]}}, a} : {64'd0, a};
        eb = (f == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [31:0] ref32(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f == 2'b01 || f == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick32();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic idle64();
        b64.in_valid  = 1'b0;
        b64.in_func   = 2'b00;
        b64.in_rs1    = '0;
        b64.in_rs2    = '0;
        b64.in_tag    = '0;
        b64.flush     = 1'b0;
        b64.out_ready = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        b64.flush = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (b64.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", b64.out_valid); end
        total++; if (b64.out_result !== 64'd0) begin bad++; $display("FAIL reset_out_result: got %0h want 0", b64.out_result); end
        total++; if (b64.out_tag !== 6'd0) begin bad++; $display("FAIL reset_out_tag: got %0h want 0", b64.out_tag); end
        total++; if (b64.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", b64.in_ready); end
        total++; if (s32.out_valid !== 1'b0) begin bad++; $display("FAIL reset_s32_out_valid: got %b want 0", s32.out_valid); end
        b64.flush = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++; if (b64.in_ready !== 1'b1 || b64.out_valid !== 1'b0) begin bad++; $display("FAIL post_reset: in_ready=%b out_valid=%b want 1/0", b64.in_ready, b64.out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        int c0, first;
        @(negedge clk);
        b64.in_valid = 1'b1; b64.in_func = 2'b00; b64.in_rs1 = 64'd3; b64.in_rs2 = 64'd5; b64.in_tag = 6'd7;
        #1;
        total++; if (b64.in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready: got %b want 1", b64.in_ready); end
        c0 = cyc;
        @(negedge clk);
        idle64();
        first = -1;
        for (int k = 0; k < 20 && first < 0; k++) begin
            #1;
            if (b64.out_valid === 1'b1) first = cyc;
            else @(negedge clk);
        end
        total++; if (first != c0 + 8) begin bad++; $display("FAIL lat_cycles: got %0d want %0d", first - c0, 8); end
        total++; if (b64.out_result !== 64'd15) begin bad++; $display("FAIL lat_result: got %0h want f", b64.out_result); end
        total++; if (b64.out_tag !== 6'd7) begin bad++; $display("FAIL lat_tag: got %0h want 7", b64.out_tag); end
        $display("test_latency: MUL 3*5 -> %0h after %0d cycles", b64.out_result, first - c0);
    endtask

    task automatic test_modes();
        logic [1:0]  fn  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [63:0] exp [4] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        int c0;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            b64.in_valid = 1'b1; b64.in_func = fn[i];
            b64.in_rs1 = '1; b64.in_rs2 = '1; b64.in_tag = 6'(20 + i);
            #1;
            total++; if (b64.in_ready !== 1'b1) begin bad++; $display("FAIL modes_in_ready[%0d]: got %b want 1", i, b64.in_ready); end
            @(negedge clk);
        end
        idle64();
        while (cyc < c0 + 8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (b64.out_valid !== 1'b1 || b64.out_result !== exp[i] || b64.out_tag !== 6'(20 + i)) begin
                bad++;
                $display("FAIL modes[%0d] func=%0d: got v=%b r=%0h t=%0d want v=1 r=%0h t=%0d",
                         i, fn[i], b64.out_valid, b64.out_result, b64.out_tag, exp[i], 20 + i);
            end
            $display("test_modes: func=%0d result=%0h tag=%0d", fn[i], b64.out_result, b64.out_tag);
            @(negedge clk);
        end
        #1;
        total++; if (b64.out_valid !== 1'b0) begin bad++; $display("FAIL modes_drain: got out_valid=%b want 0", b64.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [63:0] expq [$];
        logic [5:0]  tagq [$];
        int          sent = 0, got = 0, extra = 0;
        logic        hold = 1'b0;
        logic [63:0] held_res = '0;
        logic [5:0]  held_tag = '0;
        for (int k = 0; k < 80 && got < 10; k++) begin
            @(negedge clk);
            b64.out_ready = !(k >= 9 && k <= 13);
            if (sent < 10) begin
                b64.in_valid = 1'b1; b64.in_func = 2'b00;
                b64.in_rs1 = 64'(sent); b64.in_rs2 = 64'(sent + 1); b64.in_tag = 6'(sent);
            end else begin
                b64.in_valid = 1'b0;
            end
            #1;
            total++;
            if (b64.in_ready !== !(b64.out_valid && !b64.out_ready)) begin
                bad++; $display("FAIL bp_in_ready k=%0d: got %b want %b", k, b64.in_ready, !(b64.out_valid && !b64.out_ready));
            end
            if (hold) begin
                total++;
                if (b64.out_valid !== 1'b1 || b64.out_result !== held_res || b64.out_tag !== held_tag) begin
                    bad++; $display("FAIL bp_stable k=%0d: got v=%b r=%0h t=%0d want v=1 r=%0h t=%0d",
                                    k, b64.out_valid, b64.out_result, b64.out_tag, held_res, held_tag);
                end
            end
            hold = b64.out_valid && !b64.out_ready;
            held_res = b64.out_result;
            held_tag = b64.out_tag;
            if (b64.out_valid && b64.out_ready) begin
                total++;
                if (expq.size() == 0) begin
                    bad++; $display("FAIL bp_extra k=%0d: got r=%0h want nothing", k, b64.out_result);
                end else begin
                    if (b64.out_result !== expq[0] || b64.out_tag !== tagq[0]) begin
                        bad++; $display("FAIL bp_data k=%0d: got r=%0h t=%0d want r=%0h t=%0d",
                                        k, b64.out_result, b64.out_tag, expq[0], tagq[0]);
                    end
                    $display("test_backpressure: k=%0d result=%0d tag=%0d", k, b64.out_result, b64.out_tag);
                    void'(expq.pop_front());
                    void'(tagq.pop_front());
                    got++;
                end
            end
            if (b64.in_valid && b64.in_ready) begin
                expq.push_back(64'(sent * (sent + 1)));
                tagq.push_back(6'(sent));
                sent++;
            end
        end
        idle64();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (b64.out_valid === 1'b1) extra++;
        end
        total++; if (got != 10) begin bad++; $display("FAIL bp_count: got %0d want 10", got); end
        total++; if (extra != 0) begin bad++; $display("FAIL bp_duplicates: got %0d extra want 0", extra); end
    endtask

    task automatic test_flush();
        int ca, seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b64.in_valid = 1'b1; b64.in_func = 2'b00;
            b64.in_rs1 = 64'(i + 2); b64.in_rs2 = 64'(i + 3); b64.in_tag = 6'(10 + i);
        end
        @(negedge clk);
        idle64();
        @(negedge clk);
        // flush cycle, with an operation offered that must be ignored
        b64.flush = 1'b1; b64.in_valid = 1'b1; b64.in_rs1 = 64'd9; b64.in_rs2 = 64'd9; b64.in_tag = 6'd31;
        #1;
        total++; if (b64.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", b64.in_ready); end
        @(negedge clk);
        b64.flush = 1'b0; b64.in_valid = 1'b1; b64.in_func = 2'b00;
        b64.in_rs1 = 64'd6; b64.in_rs2 = 64'd7; b64.in_tag = 6'd33;
        #1;
        total++; if (b64.in_ready !== 1'b1) begin bad++; $display("FAIL flush_next_in_ready: got %b want 1", b64.in_ready); end
        ca = cyc;
        @(negedge clk);
        idle64();
        for (int k = 0; k < 14; k++) begin
            #1;
            if (b64.out_valid === 1'b1) begin
                total++;
                if (b64.out_tag !== 6'd33 || b64.out_result !== 64'd42 || cyc != ca + 8) begin
                    bad++; $display("FAIL flush_output: got r=%0h t=%0d at +%0d want r=2a t=33 at +8",
                                    b64.out_result, b64.out_tag, cyc - ca);
                end else begin
                    seen++;
                    $display("test_flush: result=%0d tag=%0d at +%0d", b64.out_result, b64.out_tag, cyc - ca);
                end
            end
            @(negedge clk);
        end
        total++; if (seen != 1) begin bad++; $display("FAIL flush_seen: got %0d want 1", seen); end
    endtask

    task automatic test_reset_mid();
        int c0, ca, first, stale = 0;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            b64.in_valid = 1'b1; b64.in_func = 2'b00;
            b64.in_rs1 = 64'(i + 1); b64.in_rs2 = 64'd3; b64.in_tag = 6'(40 + i);
            @(negedge clk);
        end
        idle64();
        while (cyc < c0 + 8) @(negedge clk);
        #1;
        total++; if (b64.out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre: got out_valid=%b want 1", b64.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (b64.out_valid !== 1'b0 || b64.out_result !== 64'd0 || b64.out_tag !== 6'd0) begin
            bad++; $display("FAIL rmid_async: got v=%b r=%0h t=%0d want 0/0/0", b64.out_valid, b64.out_result, b64.out_tag);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (b64.out_valid === 1'b1) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL rmid_stale: got %0d results want 0", stale); end
        @(negedge clk);
        b64.in_valid = 1'b1; b64.in_func = 2'b00; b64.in_rs1 = 64'd2; b64.in_rs2 = 64'd2; b64.in_tag = 6'd5;
        ca = cyc;
        @(negedge clk);
        idle64();
        first = -1;
        for (int k = 0; k < 20 && first < 0; k++) begin
            #1;
            if (b64.out_valid === 1'b1) first = cyc;
            else @(negedge clk);
        end
        total++;
        if (first != ca + 8 || b64.out_result !== 64'd4 || b64.out_tag !== 6'd5) begin
            bad++; $display("FAIL rmid_after: got r=%0h t=%0d lat=%0d want r=4 t=5 lat=8", b64.out_result, b64.out_tag, first - ca);
        end
        $display("test_reset_mid: MUL 2*2 -> %0h", b64.out_result);
    endtask

    localparam int NOPS = 150;

    task automatic test_sweep();
        logic [1:0]  op_f [NOPS];
        logic [31:0] op_a [NOPS];
        logic [31:0] op_b [NOPS];
        logic [5:0]  op_t [NOPS];
        int          op_c [NOPS];
        int          rd [3] = '{0, 0, 0};
        int          nis = 0;
        logic [31:0] exp;
        for (int k = 0; k < 2000; k++) begin
            if (nis == NOPS && rd[0] == NOPS && rd[1] == NOPS && rd[2] == NOPS) break;
            @(negedge clk);
            if (nis < NOPS && $urandom_range(0, 3) != 0) begin
                op_f[nis] = 2'($urandom_range(0, 3));
                op_a[nis] = pick32();
                op_b[nis] = pick32();
                op_t[nis] = 6'($urandom_range(0, 63));
                sw_valid = 1'b1; sw_func = op_f[nis]; sw_rs1 = op_a[nis]; sw_rs2 = op_b[nis]; sw_tag = op_t[nis];
            end else begin
                sw_valid = 1'b0;
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                if (sw_ov[d] === 1'b1) begin
                    total++;
                    if (rd[d] >= nis) begin
                        bad++; $display("FAIL sweep_extra st=%0d: got r=%0h want nothing", sw_stages[d], sw_res[d]);
                    end else begin
                        exp = ref32(op_f[rd[d]], op_a[rd[d]], op_b[rd[d]]);
                        if (sw_res[d] !== exp || sw_tg[d] !== op_t[rd[d]] || cyc != op_c[rd[d]] + sw_stages[d]) begin
                            bad++; $display("FAIL sweep st=%0d f=%0d a=%0h b=%0h: got r=%0h t=%0d lat=%0d want r=%0h t=%0d lat=%0d",
                                            sw_stages[d], op_f[rd[d]], op_a[rd[d]], op_b[rd[d]], sw_res[d], sw_tg[d],
                                            cyc - op_c[rd[d]], exp, op_t[rd[d]], sw_stages[d]);
                        end
                        $display("test_sweep: st=%0d f=%0d a=%0h b=%0h r=%0h", sw_stages[d], op_f[rd[d]], op_a[rd[d]], op_b[rd[d]], sw_res[d]);
                        rd[d]++;
                    end
                end else if (rd[d] < nis && cyc >= op_c[rd[d]] + sw_stages[d]) begin
                    total++; bad++;
                    $display("FAIL sweep_missing st=%0d op=%0d: got no result want r=%0h",
                             sw_stages[d], rd[d], ref32(op_f[rd[d]], op_a[rd[d]], op_b[rd[d]]));
                    rd[d]++;
                end
            end
            if (sw_valid) begin
                total++;
                if (sw_ir[0] !== 1'b1 || sw_ir[1] !== 1'b1 || sw_ir[2] !== 1'b1) begin
                    bad++; $display("FAIL sweep_in_ready: got %b%b%b want 111", sw_ir[0], sw_ir[1], sw_ir[2]);
                end
                op_c[nis] = cyc;
                nis++;
            end
        end
        sw_valid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (rd[d] != NOPS) begin bad++; $display("FAIL sweep_count st=%0d: got %0d want %0d", sw_stages[d], rd[d], NOPS); end
        end
    endtask

    initial begin
        idle64();
        sw_valid = 1'b0; sw_func = 2'b00; sw_rs1 = '0; sw_rs2 = '0; sw_tag = '0;
        test_reset();
        test_latency();
        test_modes();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Parametrised pipelined integer multiplier; successor to the fixed 64-bit, low-half-only, unsigned-only, no-backpressure multiplier.
- Generalised in operand width and stage count.
- Adds RISC-V M-extension modes (MUL/MULH/MULHSU/MULHU), a tag carried alongside each operation, valid/ready backpressure and a synchronous flush.
- Sits in the execute stage as the multiply functional unit; results go to the completion/CDB arbiter.

Parameters:
XLEN, 64, operand and result width in bits; must be >= 8.
STAGES, 8, pipeline depth in registered stages; must divide XLEN, range 1..XLEN.
TAG_W, 6, width of the opaque tag (ROB index) passed through with each operation.

Ports:
clock  in  1  system clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-low reset: 0 clears all state immediately, independent of clock.
in_valid  in  1  operation presented on the in_* ports.
in_ready  out  1  unit accepts the operation this cycle.
in_func  in  2  mode: 00 MUL (low half), 01 MULH (signed x signed, high), 10 MULHSU (signed rs1 x unsigned rs2, high), 11 MULHU (unsigned x unsigned, high).
in_rs1  in  XLEN  multiplicand.
in_rs2  in  XLEN  multiplier.
in_tag  in  TAG_W  tag returned with the result.
flush  in  1  synchronous kill of every in-flight operation.
out_valid  out  1  result on out_result/out_tag is valid.
out_ready  in  1  consumer takes the result this cycle.
out_result  out  XLEN  selected XLEN-bit half of the exact 2*XLEN-bit product.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (reset==0):
  - All stage valid bits, partial sums and operand registers clear to 0.
  - out_valid=0, out_result=0, out_tag=0.
  - in_ready is combinational and reads 1 while in reset.
  - Reset mid-operation discards all in-flight operations; no result ever appears for them.
- Pipeline: STAGES register stages; each consumes XLEN/STAGES multiplier bits (LSB first), adding the shifted multiplicand partial product into a 2*XLEN-bit running sum. Each stage registers: valid, func, tag, sum, shifted mcand, remaining mplier.
- Sign handling:
  - rs1 is sign-extended to 2*XLEN when func is MULH or MULHSU, zero-extended otherwise.
  - For MULH only, if rs2[XLEN-1]==1 the final stage subtracts (extended rs1 << XLEN) from the sum.
  - All sums are modulo 2^(2*XLEN).
- Result selection: MUL gives product[XLEN-1:0]; other modes give product[2*XLEN-1:XLEN]. out_result is registered, with no combinational path from in_* to out_*.
- Latency: an operation accepted in cycle N shows out_valid=1 at cycle N+STAGES when there is no stall.
- Throughput: one operation per cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - When advance==0, every stage holds its contents and out_* stay stable until taken.
  - Bubbles do not compress during a stall; the whole pipe freezes.
  - When advance==1 with no input, a bubble (valid=0) enters stage 0.
- Flush:
  - On a cycle with flush==1, all stage valid bits and out_valid clear at the next edge.
  - in_valid is ignored that cycle, and in_ready is forced to 0 while flush==1.
  - Flush takes priority over out_ready; a result presented in a flush cycle counts as transferred only if out_ready==1 in that same cycle.
- Data and tag of bubbles are don't-care, but must never produce out_valid.
- Outputs and pipeline registers never go X after reset.

Test Plan:
- MUL, XLEN=64, rs1=3, rs2=5, tag=7, out_ready=1 -> out_valid exactly 8 cycles after acceptance, out_result=15, out_tag=7.
- rs1=rs2=0xFFFFFFFFFFFFFFFF, modes issued back-to-back in consecutive cycles:
  - MULH -> 0x0000000000000000.
  - MULHU -> 0xFFFFFFFFFFFFFFFE.
  - MULHSU -> 0xFFFFFFFFFFFFFFFF.
  - MUL -> 0x0000000000000001.
  - Results arrive in order on consecutive cycles, tags preserved.
- Backpressure: stream 10 operations (rs1=i, rs2=i+1, MUL) with out_ready low for cycles 9-13 -> in_ready low exactly while out_valid && !out_ready; out_result held stable; all 10 results i*(i+1) delivered once, in order, with none dropped or duplicated.
- Flush: issue 4 MULs in consecutive cycles, assert flush 2 cycles after the last, then issue MUL 6*7 -> none of the first 4 appear; only 42 appears, with its tag, 8 cycles after its acceptance.
- Reset mid-operation: issue 3 operations, drive reset=0 asynchronously between edges for 1 cycle -> out_valid drops to 0 immediately; no stale result after release; a new MUL 2*2 yields 4.
- Parameter sweep with XLEN=32, STAGES in {1,4,32}: random signed/unsigned operands in all 4 modes compared against a 64-bit reference model -> bit-exact results with latency equal to STAGES.
